gpio_serial_loader: RTL

Parametrised serial configuration loader for the user-project I/O control chains, instantiated inside mgmt_soc. It shifts per-pad configuration words from the SoC register file into NUM_CHAINS parallel daisy-chains at the same time. It generates the shared chain reset and shift clock, and one data line per chain. It generalises the fixed two-chain loader to N chains, a programmable pad count and word width, clock division, and one queued transfer request.

---
 rtl/gpio_loader_pkg.sv | 25 ++
 rtl/gpio_serial_loader_if.sv | 29 ++
 rtl/gpio_loader_tick.sv | 28 ++
 rtl/gpio_serial_loader.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/gpio_loader_pkg.sv
// Shared types and index helpers for the GPIO serial configuration loader.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package gpio_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RST   = 3'd1,
        SETUP = 3'd2,
        HIGH  = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Serial bits shifted into each chain per transfer.
    function automatic int n_bits(input int pads, input int bits);
        return pads * bits;
    endfunction

    // Position of (chain, pad, bit) inside the flat cfg_words vector.
    function automatic int cfg_index(input int chain, input int pad, input int bit_n,
                                     input int pads, input int bits);
        return ((chain * pads) + pad) * bits + bit_n;
    endfunction

endpackage

// File: rtl/gpio_serial_loader_if.sv
// Host-side bundle of the GPIO loader: request, config words, status and chain drive.
// Latency: none (wires only).
// Backpressure: none; a request during a transfer is queued one deep by the loader.
interface gpio_serial_loader_if #(
    parameter int NUM_CHAINS     = 2,
    parameter int PADS_PER_CHAIN = 19,
    parameter int BITS_PER_PAD   = 13
);
    localparam int CFG_W = NUM_CHAINS * PADS_PER_CHAIN * BITS_PER_PAD;

    logic                  xfer;
    logic [CFG_W-1:0]      cfg_words;
    logic                  busy;
    logic                  done;
    logic                  pending;
    logic                  loader_resetn;
    logic                  loader_clock;
    logic [NUM_CHAINS-1:0] loader_data;

    modport master (
        output xfer, cfg_words,
        input  busy, done, pending, loader_resetn, loader_clock, loader_data
    );

    modport slave (
        input  xfer, cfg_words,
        output busy, done, pending, loader_resetn, loader_clock, loader_data
    );
endinterface

// File: rtl/gpio_loader_tick.sv
// Phase counter that stretches every loader state to CLK_DIV clk cycles.
// Latency: phase_last_o asserts CLK_DIV-1 cycles after the last clear.
// Backpressure: none; clr_i restarts the count on every state change.
module gpio_loader_tick #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic resetn,
    input  logic clr_i,
    output logic phase_last_o
);
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] phase_q;

    assign phase_last_o = (phase_q == PW'(CLK_DIV - 1));

    // Count 0..CLK_DIV-1, restarting on clear or after the final phase.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            phase_q <= '0;
        end else if (clr_i || phase_last_o) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + PW'(1);
        end
    end
endmodule

// File: rtl/gpio_serial_loader.sv
// Shifts per-pad config words into NUM_CHAINS parallel daisy-chains (pad N-1 / MSB first).
// Latency: busy one cycle after xfer, high CLK_DIV*(1+2*N_BITS) cycles, then one-cycle done.
// Backpressure: one request queued while busy (pending); GPIO_LOADER_AUTOLOAD_EN queues one at reset.
module gpio_serial_loader
    import gpio_loader_pkg::*;
#(
    parameter int NUM_CHAINS     = 2,
    parameter int PADS_PER_CHAIN = 19,
    parameter int BITS_PER_PAD   = 13,
    parameter int CLK_DIV        = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    gpio_serial_loader_if.slave   bus
);
    localparam int N_BITS = n_bits(PADS_PER_CHAIN, BITS_PER_PAD);
    localparam int CFG_W  = NUM_CHAINS * N_BITS;
    localparam int IDX_W  = (CFG_W > 1) ? $clog2(CFG_W) : 1;
    localparam int PAD_W  = (PADS_PER_CHAIN > 1) ? $clog2(PADS_PER_CHAIN) : 1;
    localparam int BIT_W  = (BITS_PER_PAD > 1) ? $clog2(BITS_PER_PAD) : 1;
    localparam logic [PAD_W-1:0] PAD_TOP = PAD_W'(PADS_PER_CHAIN - 1);
    localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(BITS_PER_PAD - 1);
`ifdef GPIO_LOADER_AUTOLOAD_EN
    localparam logic PEND_RST = 1'b1;
`else
    localparam logic PEND_RST = 1'b0;
`endif

    state_t                state_q;
    logic                  busy_q, done_q, pending_q, lrn_q, lclk_q;
    logic [NUM_CHAINS-1:0] data_q, data_d;
    logic [PAD_W-1:0]      pad_q, pad_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  phase_last, advance, start, last_bit, tick_clr;

    assign start    = bus.xfer | pending_q;
    assign last_bit = (pad_q == '0) && (bit_q == '0);
    assign tick_clr = (state_q == IDLE) || advance;

    gpio_loader_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk          (clk),
        .resetn       (resetn),
        .clr_i        (tick_clr),
        .phase_last_o (phase_last)
    );

    // Leave the current state: IDLE on a request, FIN after one cycle, others after CLK_DIV cycles.
    always_comb begin
        advance = 1'b0;
        case (state_q)
            IDLE:              advance = start;
            RST, SETUP, HIGH:  advance = phase_last;
            FIN:               advance = 1'b1;
            default:           advance = 1'b0;
        endcase
    end

    // Next bit position (pad-major countdown) and the per-chain bit presented in the next SETUP.
    always_comb begin
        pad_d = pad_q;
        bit_d = bit_q;
        if (state_q == RST) begin
            pad_d = PAD_TOP;
            bit_d = BIT_TOP;
        end else if (state_q == HIGH) begin
            if (bit_q == '0) begin
                bit_d = BIT_TOP;
                pad_d = pad_q - PAD_W'(1);
            end else begin
                bit_d = bit_q - BIT_W'(1);
            end
        end
        data_d = '0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            data_d[c] = bus.cfg_words[IDX_W'(cfg_index(c, int'(pad_d), int'(bit_d),
                                                       PADS_PER_CHAIN, BITS_PER_PAD))];
        end
    end

    // Transfer sequencer with registered chain drive and status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pending_q <= PEND_RST;
            lrn_q     <= 1'b1;
            lclk_q    <= 1'b0;
            data_q    <= '0;
            pad_q     <= '0;
            bit_q     <= '0;
        end else begin
            done_q <= 1'b0;
            // IDLE consumes the queued request; any other state (FIN included) queues one.
            if (state_q == IDLE) begin
                if (start) pending_q <= 1'b0;
            end else if (bus.xfer) begin
                pending_q <= 1'b1;
            end
            if (advance) begin
                case (state_q)
                    IDLE: begin
                        state_q <= RST;
                        busy_q  <= 1'b1;
                        lrn_q   <= 1'b0;
                    end
                    RST: begin
                        state_q <= SETUP;
                        lrn_q   <= 1'b1;
                        pad_q   <= pad_d;
                        bit_q   <= bit_d;
                        data_q  <= data_d;
                    end
                    SETUP: begin
                        state_q <= HIGH;
                        lclk_q  <= 1'b1;
                    end
                    HIGH: begin
                        lclk_q <= 1'b0;
                        if (last_bit) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            data_q  <= '0;
                            pad_q   <= '0;
                            bit_q   <= '0;
                        end else begin
                            state_q <= SETUP;
                            pad_q   <= pad_d;
                            bit_q   <= bit_d;
                            data_q  <= data_d;
                        end
                    end
                    FIN:     state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pending       = pending_q;
    assign bus.loader_resetn = lrn_q;
    assign bus.loader_clock  = lclk_q;
    assign bus.loader_data   = data_q;

endmodule
